// File: rtl/sfq_pulse_result_checker_pkg.sv
// Shared types and defaults for the SFQ adder readout checker.
// The arm state enum is also exported on the interface for observability.
package sfq_rx_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic                 cout;
    logic [DEF_WIDTH-1:0] sum;
  } res_t;

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } arm_state_e;

  function automatic res_t exp_sum(input logic [DEF_WIDTH-1:0] a,
                                   input logic [DEF_WIDTH-1:0] b,
                                   input logic                 cin);
    logic [DEF_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b} + (DEF_WIDTH + 1)'(cin);
    return res_t'(s);
  endfunction

endpackage

// File: rtl/sfq_pulse_result_checker_if.sv
// Pad, operand and result bundle between the adder harness and the readout checker.
// Strobes (op_valid, res_valid, spurious) are single-cycle with no back-pressure; data is meaningful only alongside its strobe.
interface sfq_pulse_result_checker_if
  import sfq_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             GCLK_Pad;
  logic [WIDTH-1:0] sum_Pad;
  logic             cout_Pad;
  logic             op_valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_match;
  logic             spurious;
  logic             overflow;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] win_count;
  arm_state_e       dbg_state;

  modport slave (
    input  GCLK_Pad, sum_Pad, cout_Pad, op_valid, op_a, op_b, op_cin,
    output res_valid, res_sum, res_cout, res_match, spurious, overflow,
           err_count, win_count, dbg_state
  );

  modport master (
    output GCLK_Pad, sum_Pad, cout_Pad, op_valid, op_a, op_b, op_cin,
    input  res_valid, res_sum, res_cout, res_match, spurious, overflow,
           err_count, win_count, dbg_state
  );

endinterface

// File: rtl/sfq_pulse_edge.sv
// Single sync flop per pad followed by a registered rising-edge detect.
// All lanes share the same delay so GCLK and data edges stay cycle-aligned.
module sfq_pulse_edge #(
  parameter int N = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] pad_i,
  output logic [N-1:0] edge_o
);

  logic [N-1:0] sync_q;
  logic [N-1:0] prev_q;
  logic [N-1:0] edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q <= pad_i;
      prev_q <= sync_q;
      edge_q <= sync_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/sfq_pulse_result_checker.sv
// Collapses data pulses per GCLK window into a result word and checks it against
// the operand queued LATENCY windows earlier; counts mismatches and spurious words.
module sfq_pulse_result_checker
  import sfq_rx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LATENCY   = 5,
  parameter int EXP_DEPTH = 8,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic                       SCLK_Pad,
  input logic                       rst_Pad,
  sfq_pulse_result_checker_if.slave bus
);

  localparam int AW = $clog2(EXP_DEPTH);

  logic [WIDTH+1:0] edges;
  logic             gclk_edge;
  logic [WIDTH:0]   data_edge;

  sfq_pulse_edge #(.N(WIDTH + 2)) u_edge (
    .clk_i  (SCLK_Pad),
    .rst_i  (rst_Pad),
    .pad_i  ({bus.GCLK_Pad, bus.cout_Pad, bus.sum_Pad}),
    .edge_o (edges)
  );

  assign gclk_edge = edges[WIDTH+1];
  assign data_edge = edges[WIDTH:0];

  arm_state_e         state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d, snap_q, op_word, head;
  logic               pend_q, pend_d, chk_q, emerge_q;
  logic [LATENCY-1:0] align_q, align_d;
  logic [WIDTH:0]     mem_q [EXP_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               armed_edge, push, pop, hit, err_inc;
  logic               overflow_q, overflow_d;
  logic               res_valid_q, res_cout_q, res_match_q, spurious_q;
  logic [WIDTH-1:0]   res_sum_q;
  logic [CNT_W-1:0]   err_q, err_d, win_q;

  always_comb begin
    armed_edge = gclk_edge && (state_q == ST_ARMED);
    state_d    = gclk_edge ? ST_ARMED : state_q;
    // A data edge coincident with the closing GCLK edge opens the new window.
    acc_d      = (gclk_edge ? '0 : acc_q) | data_edge;
    op_word    = {1'b0, bus.op_a} + {1'b0, bus.op_b} + (WIDTH + 1)'(bus.op_cin);
    push       = bus.op_valid && !(pend_q && !armed_edge) &&
                 (cnt_q != (AW + 1)'(EXP_DEPTH));
    overflow_d = overflow_q | (bus.op_valid && !push);
    pend_d     = (armed_edge ? 1'b0 : pend_q) | push;
    align_d    = armed_edge ? ((align_q << 1) | LATENCY'(pend_q)) : align_q;
    head       = mem_q[rd_ptr_q];
    hit        = (cnt_q != '0) && (snap_q == head);
    pop        = chk_q && emerge_q && (cnt_q != '0);
    err_inc    = chk_q && (emerge_q ? !hit : (snap_q != '0));
    err_d      = (err_inc && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
    cnt_d      = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  always_ff @(posedge SCLK_Pad) begin
    if (rst_Pad) begin
      state_q     <= ST_DISARMED;
      acc_q       <= '0;
      snap_q      <= '0;
      pend_q      <= 1'b0;
      chk_q       <= 1'b0;
      emerge_q    <= 1'b0;
      align_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      err_q       <= '0;
      win_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_match_q <= 1'b0;
      spurious_q  <= 1'b0;
      for (int i = 0; i < EXP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      align_q    <= align_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      chk_q      <= armed_edge;
      if (gclk_edge) snap_q <= acc_q;
      if (armed_edge) begin
        emerge_q <= align_q[LATENCY-1];
        win_q    <= win_q + CNT_W'(1);
      end
      if (push) begin
        mem_q[wr_ptr_q] <= op_word;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      res_valid_q <= chk_q && emerge_q;
      spurious_q  <= chk_q && !emerge_q && (snap_q != '0);
      if (chk_q && emerge_q) begin
        res_sum_q   <= snap_q[WIDTH-1:0];
        res_cout_q  <= snap_q[WIDTH];
        res_match_q <= hit;
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_match = res_match_q;
  assign bus.spurious  = spurious_q;
  assign bus.overflow  = overflow_q;
  assign bus.err_count = err_q;
  assign bus.win_count = win_q;
  assign bus.dbg_state = state_q;

endmodule
